// File: rtl/sprite_draw_scheduler.sv
// Serialises full-screen clears and per-sprite erase/redraw into one VGA pixel write per clock.
// Four sticky request bits are serviced in fixed priority: clear, player, enemy 0, enemy 1.
module sprite_draw_scheduler #(
  parameter int unsigned SCREEN_W      = 160,
  parameter int unsigned SCREEN_H      = 120,
  parameter int unsigned PLAYER_WIDTH  = 3,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [2:0]  PLAYER_COLOUR = 3'b111,
  parameter logic [2:0]  ENEMY_COLOUR  = 3'b100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear_req,
  input  logic       player_move,
  input  logic [7:0] playerX,
  input  logic [6:0] playerY,
  input  logic       e0_move,
  input  logic [7:0] e0X,
  input  logic [6:0] e0Y,
  input  logic [2:0] e0_width,
  input  logic       e1_move,
  input  logic [7:0] e1X,
  input  logic [6:0] e1Y,
  input  logic [2:0] e1_width,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int unsigned NOBJ = 3;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ERASE, S_DRAW} state_t;

  state_t     state;
  logic       clr_p, pl_p, e0_p, e1_p;
  logic [1:0] obj;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] new_w;
  logic [7:0] prev_x [NOBJ];
  logic [6:0] prev_y [NOBJ];
  logic [2:0] prev_w [NOBJ];
  logic [2:0] valid;
  logic [7:0] cx;
  logic [6:0] cy;

  // Fixed-priority selection, only meaningful while idle
  logic sel_clr, sel_pl, sel_e0, sel_e1;
  always_comb begin
    sel_clr = (state == S_IDLE) & clr_p;
    sel_pl  = (state == S_IDLE) & ~clr_p & pl_p;
    sel_e0  = (state == S_IDLE) & ~clr_p & ~pl_p & e0_p;
    sel_e1  = (state == S_IDLE) & ~clr_p & ~pl_p & ~e0_p & e1_p;
  end

  logic [1:0] sel_obj;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_w;
  always_comb begin
    sel_obj = 2'd0;
    sel_x   = playerX;
    sel_y   = playerY;
    sel_w   = 3'(PLAYER_WIDTH);
    if (sel_e0) begin
      sel_obj = 2'd1;
      sel_x   = e0X;
      sel_y   = e0Y;
      sel_w   = (e0_width == 3'd0) ? 3'd1 : e0_width;
    end else if (sel_e1) begin
      sel_obj = 2'd2;
      sel_x   = e1X;
      sel_y   = e1Y;
      sel_w   = (e1_width == 3'd0) ? 3'd1 : e1_width;
    end
  end

  // Square scan geometry; sums are one bit wider so off-screen pixels never wrap
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] cur_w, w_last;
  logic [8:0] sx;
  logic [7:0] sy;
  logic       on_screen, row_end, sq_last, clr_row_end, clr_last;
  always_comb begin
    base_x = new_x;
    base_y = new_y;
    cur_w  = new_w;
    if (state == S_ERASE) begin
      base_x = prev_x[obj];
      base_y = prev_y[obj];
      cur_w  = prev_w[obj];
    end
    w_last      = cur_w - 3'd1;
    sx          = {1'b0, base_x} + 9'(cx);
    sy          = {1'b0, base_y} + 8'(cy);
    on_screen   = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
    row_end     = (cx == 8'(w_last));
    sq_last     = row_end && (cy == 7'(w_last));
    clr_row_end = (cx == 8'(SCREEN_W - 1));
    clr_last    = clr_row_end && (cy == 7'(SCREEN_H - 1));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      clr_p  <= 1'b1;
      pl_p   <= 1'b0;
      e0_p   <= 1'b0;
      e1_p   <= 1'b0;
      obj    <= 2'd0;
      new_x  <= 8'd0;
      new_y  <= 7'd0;
      new_w  <= 3'd0;
      valid  <= 3'b000;
      cx     <= 8'd0;
      cy     <= 7'd0;
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      for (int i = 0; i < NOBJ; i++) begin
        prev_x[i] <= 8'd0;
        prev_y[i] <= 7'd0;
        prev_w[i] <= 3'd0;
      end
    end else begin
      // New pulses win over the clear caused by selection
      clr_p <= (clr_p & ~sel_clr) | clear_req;
      pl_p  <= (pl_p  & ~sel_pl)  | player_move;
      e0_p  <= (e0_p  & ~sel_e0)  | e0_move;
      e1_p  <= (e1_p  & ~sel_e1)  | e1_move;

      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          cx   <= 8'd0;
          cy   <= 7'd0;
          if (sel_clr) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
          end else if (sel_pl | sel_e0 | sel_e1) begin
            obj   <= sel_obj;
            new_x <= sel_x;
            new_y <= sel_y;
            new_w <= sel_w;
            busy  <= 1'b1;
            state <= valid[sel_obj] ? S_ERASE : S_DRAW;
          end
        end

        S_CLEAR: begin
          x      <= cx;
          y      <= cy;
          colour <= BG_COLOUR;
          plot   <= 1'b1;
          if (clr_row_end) begin
            cx <= 8'd0;
            cy <= cy + 7'd1;
          end else begin
            cx <= cx + 8'd1;
          end
          // A cleared screen invalidates every sprite and forces all to redraw
          if (clr_last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            valid <= 3'b000;
            pl_p  <= 1'b1;
            e0_p  <= 1'b1;
            e1_p  <= 1'b1;
          end
        end

        S_ERASE, S_DRAW: begin
          x      <= sx[7:0];
          y      <= sy[6:0];
          plot   <= on_screen;
          colour <= (state == S_ERASE) ? BG_COLOUR :
                    ((obj == 2'd0) ? PLAYER_COLOUR : ENEMY_COLOUR);
          if (sq_last) begin
            cx <= 8'd0;
            cy <= 7'd0;
            if (state == S_ERASE) begin
              state <= S_DRAW;
            end else begin
              state       <= S_IDLE;
              busy        <= 1'b0;
              prev_x[obj] <= new_x;
              prev_y[obj] <= new_y;
              prev_w[obj] <= new_w;
              valid[obj]  <= 1'b1;
            end
          end else if (row_end) begin
            cx <= 8'd0;
            cy <= cy + 7'd1;
          end else begin
            cx <= cx + 8'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: stimulus pushes expected pixels, a monitor pops on plot.
module tb_sprite_draw_scheduler;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam logic [2:0] BG = 3'b000;
  localparam logic [2:0] PC = 3'b111;
  localparam logic [2:0] EC = 3'b100;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear_req = 1'b0;
  logic       player_move = 1'b0, e0_move = 1'b0, e1_move = 1'b0;
  logic [7:0] playerX = 8'd0, e0X = 8'd0, e1X = 8'd0;
  logic [6:0] playerY = 7'd0, e0Y = 7'd0, e1Y = 7'd0;
  logic [2:0] e0_width = 3'd0, e1_width = 3'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy;

  sprite_draw_scheduler dut (
    .clk(clk), .resetn(resetn), .clear_req(clear_req),
    .player_move(player_move), .playerX(playerX), .playerY(playerY),
    .e0_move(e0_move), .e0X(e0X), .e0Y(e0Y), .e0_width(e0_width),
    .e1_move(e1_move), .e1X(e1X), .e1Y(e1Y), .e1_width(e1_width),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  first_cyc = 0;
  int  last_cyc = 0;
  bit  arm = 1'b0;
  bit  mon_en = 1'b0;
  px_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every plotted pixel must match the head of the expected queue
  always @(negedge clk) begin
    if (mon_en && plot === 1'b1) begin
      px_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot got (%0d,%0d,%b) with empty queue", x, y, colour);
      end else begin
        e = q.pop_front();
        if (x !== e.x || y !== e.y || colour !== e.c) begin
          errors++;
          $display("FAIL pixel got (%0d,%0d,%b) want (%0d,%0d,%b)", x, y, colour, e.x, e.y, e.c);
        end
      end
      last_cyc = cyc;
      if (arm) begin
        first_cyc = cyc;
        arm = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Reference model of each object's last drawn square
  int mx[3], my[3], mw[3];
  bit mv[3];

  task automatic push_sq(input int bx, input int by, input int w, input logic [2:0] c);
    px_t p;
    for (int dy = 0; dy < w; dy++)
      for (int dx = 0; dx < w; dx++)
        if (bx + dx < SW && by + dy < SH) begin
          p.x = 8'(bx + dx);
          p.y = 7'(by + dy);
          p.c = c;
          q.push_back(p);
        end
  endtask

  task automatic push_clear();
    px_t p;
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++) begin
        p.x = 8'(xx);
        p.y = 7'(yy);
        p.c = BG;
        q.push_back(p);
      end
    for (int i = 0; i < 3; i++) mv[i] = 1'b0;
  endtask

  task automatic service(input int o, input int nx, input int ny, input int w_in, output int len);
    int w;
    w = (o == 0) ? 3 : ((w_in == 0) ? 1 : w_in);
    len = w * w;
    if (mv[o]) begin
      push_sq(mx[o], my[o], mw[o], BG);
      len = len + mw[o] * mw[o];
    end
    push_sq(nx, ny, w, (o == 0) ? PC : EC);
    mx[o] = nx; my[o] = ny; mw[o] = w; mv[o] = 1'b1;
  endtask

  int tp;
  task automatic pulse(input bit p, input bit a, input bit b, input bit c);
    @(negedge clk);
    player_move = p; e0_move = a; e1_move = b; clear_req = c;
    @(posedge clk);
    #1;
    tp = cyc;
    player_move = 1'b0; e0_move = 1'b0; e1_move = 1'b0; clear_req = 1'b0;
  endtask

  // Edges after the pulse edge until busy returns low
  task automatic busy_len(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy === 1'b1 && n < 30000);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(q.size() == 0 && busy === 1'b0) && n < 25000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 25000) begin
      errors++;
      $display("FAIL %s timeout queue=%0d busy=%b", tag, q.size(), busy);
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_queue_left"}, q.size(), 0);
  endtask

  int n, l0, l1, l2;

  initial begin
    for (int i = 0; i < 3; i++) begin mx[i] = 0; my[i] = 0; mw[i] = 0; mv[i] = 1'b0; end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);

    // Reset mid-sweep aborts at that edge
    @(negedge clk) resetn = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("sweep_plot", int'(plot), 1);
    check("sweep_busy", int'(busy), 1);
    @(negedge clk) resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(posedge clk);

    // Scenario 1: power-up clear then initial draws
    mon_en = 1'b1;
    push_clear();
    service(0, 0, 0, 3, l0);
    service(1, 0, 0, 0, l1);
    service(2, 0, 0, 0, l2);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    check("clear_enter_busy", int'(busy), 1);
    check("clear_enter_plot", int'(plot), 0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy === 1'b1 && n < 20000);
    check("clear_cycles", n, 19200);
    wait_done("s1");

    // Scenario 2: player move, erase then draw, first pixel two edges after the pulse
    playerX = 8'd80; playerY = 7'd115;
    service(0, 80, 115, 3, l0);
    pulse(1, 0, 0, 0);
    busy_len(n);
    check("s2a_busy_len", n, 1 + l0);
    wait_done("s2a");
    playerX = 8'd79;
    service(0, 79, 115, 3, l0);
    arm = 1'b1;
    pulse(1, 0, 0, 0);
    busy_len(n);
    check("s2b_busy_len", n, 19);
    check("s2b_first_px", first_cyc - tp, 2);
    wait_done("s2b");

    // Scenario 3: simultaneous pulses served in priority order with one idle cycle between
    playerX = 8'd20; playerY = 7'd30;
    e0X = 8'd40; e0Y = 7'd50; e0_width = 3'd2;
    e1X = 8'd50; e1Y = 7'd50; e1_width = 3'd3;
    service(0, 20, 30, 3, l0);
    service(1, 40, 50, 2, l1);
    service(2, 50, 50, 3, l2);
    pulse(1, 1, 1, 0);
    wait_done("s3");
    check("s3_last_px", last_cyc - tp, 3 + l0 + l1 + l2);

    // Scenario 4: clipping at the bottom-right corner
    e0X = 8'd158; e0Y = 7'd118; e0_width = 3'd4;
    service(1, 158, 118, 4, l1);
    pulse(0, 1, 0, 0);
    busy_len(n);
    check("s4a_busy_len", n, 1 + l1);
    wait_done("s4a");
    service(1, 158, 118, 4, l1);
    pulse(0, 1, 0, 0);
    busy_len(n);
    check("s4b_busy_len", n, 33);
    wait_done("s4b");

    // Scenario 6: re-pulse during own erase uses coordinates at the second latch
    e0X = 8'd10; e0Y = 7'd10; e0_width = 3'd2;
    service(1, 10, 10, 2, l1);
    pulse(0, 1, 0, 0);
    repeat (3) @(posedge clk);
    e0X = 8'd20; e0Y = 7'd20;
    service(1, 20, 20, 2, l2);
    pulse(0, 1, 0, 0);
    wait_done("s6");

    // Scenario 5: clear mid-draw lets the sprite finish, then all sprites redraw without erase
    e1X = 8'd60; e1Y = 7'd60;
    service(2, 60, 60, 3, l2);
    push_clear();
    service(0, 20, 30, 3, l0);
    service(1, 20, 20, 2, l1);
    service(2, 60, 60, 3, l2);
    pulse(0, 0, 1, 0);
    repeat (11) @(posedge clk);
    pulse(0, 0, 0, 1);
    wait_done("s5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Downstream rendering stage for the dodge game. Consumes the position and `move` outputs of the player controller and two enemy controllers, and serialises erase/redraw of each sprite into one pixel write per clock for the 160x120 VGA adapter. Also performs a full-screen clear on reset and on level load.

## Interface

**Parameters**
- `SCREEN_W`, default 160: screen width in pixels.
- `SCREEN_H`, default 120: screen height in pixels.
- `PLAYER_WIDTH`, default 3: side length of the square player sprite.
- `BG_COLOUR`, default 3'b000: background and erase colour.
- `PLAYER_COLOUR`, default 3'b111: player sprite colour.
- `ENEMY_COLOUR`, default 3'b100: enemy sprite colour.

**Ports**
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset; synchronous, active-low.
- `clear_req`, in, 1: request a full-screen clear (driven by level load).
- `player_move`, in, 1: one-cycle pulse; player position changed.
- `playerX`, in, 8; `playerY`, in, 7: player top-left corner.
- `e0_move`, in, 1; `e0X`, in, 8; `e0Y`, in, 7; `e0_width`, in, 3: enemy 0 pulse, position and width.
- `e1_move`, in, 1; `e1X`, in, 8; `e1Y`, in, 7; `e1_width`, in, 3: enemy 1, same meaning as enemy 0.
- `x`, out, 8; `y`, out, 7; `colour`, out, 3: pixel write data for the VGA adapter.
- `plot`, out, 1: write enable for `x`/`y`/`colour`.
- `busy`, out, 1: high in every state other than IDLE.

## Operation

**Pending bits**
- There are four sticky bits: `clr_p`, `pl_p`, `e0_p`, `e1_p`.
- A high `*_move` or `clear_req` sampled at a clock edge sets the matching bit, in any state.
- A bit is cleared only at the edge where IDLE selects it for service. If a set and a clear hit the same bit on the same edge, the set wins.
- Multiple pulses arriving before service merge into one pending request.

**Stored state**
- Each object keeps a previous-position register (`prevX`, `prevY`, `prevW`) and a `valid` bit.

**State machine: IDLE, CLEAR, ERASE, DRAW**
- **IDLE**
  - Service priority is `clr_p` > `pl_p` > `e0_p` > `e1_p`.
  - When servicing `clr_p`, go to CLEAR.
  - When servicing an object, latch its current inputs into new-position registers, then go to ERASE if its `valid`=1, else to DRAW.
  - With nothing pending, stay in IDLE with `plot`=0.
- **CLEAR**
  - Sweep x=0..SCREEN_W-1 (inner loop) by y=0..SCREEN_H-1 (outer loop) in `BG_COLOUR`: 19200 cycles, `plot`=1 on every cycle.
  - On exit: all `valid` bits go to 0, `pl_p`/`e0_p`/`e1_p` are set, and the state returns to IDLE.
- **ERASE**
  - Scan a w x w square at `prev` in `BG_COLOUR`, x offset inner, y offset outer, one pixel per cycle. `w` is `prevW`.
  - Then go to DRAW.
- **DRAW**
  - Scan a w x w square at the latched new position in the object's colour.
  - Copy the new position to `prev`, set `valid`=1, and return to IDLE.

**Width and clipping rules**
- Player w = `PLAYER_WIDTH`. Enemy w = `*_width`; a width of 0 is treated as 1.
- A pixel with x ≥ SCREEN_W or y ≥ SCREEN_H drives `plot`=0 but still consumes its cycle.
- Coordinate sums are computed at 9 bits (x) and 8 bits (y) so they never wrap.

**Mid-operation events**
- `clear_req` arriving during ERASE or DRAW does not abort the sprite in progress; the clear is serviced at the next IDLE.
- Input coordinates are sampled only at the latch edge. Changes after that edge affect the next service only.

## Timing

- Reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, all `valid`=0, `pl_p`/`e0_p`/`e1_p`=0, `clr_p`=1, state=IDLE. The first edge after reset is released enters CLEAR.
- `resetn` low mid-sweep aborts immediately at that edge.
- All outputs are registered. A move pulse sampled at edge t (in IDLE, no other pending) causes:
  - latch at edge t+1;
  - first `plot`=1 pixel visible after edge t+2.
- Service length per object:
  - first draw: w² cycles;
  - redraw: 2·w² cycles (erase then draw, back-to-back with no gap cycle between them).
- IDLE costs exactly one cycle between consecutive services.
- CLEAR entry to IDLE takes 19200 pixel cycles.
- `busy` goes high on the edge that leaves IDLE and low on the edge that returns to IDLE.

## Test plan

1. **Reset, then quiet.** Release reset with all inputs 0. Required: exactly 19200 `plot` cycles with `colour`=000 covering every (x,y) once. Then the player draws at its inputs (9 pixels, 111), e0 draws, e1 draws, then `busy`=0.
2. **Player move.** playerX 80→79, one `player_move` pulse. Required: 9 erase pixels at (80..82,115..117) with colour 000, then 9 pixels at (79..81,115..117) with colour 111. The first pixel appears 2 cycles after the pulse.
3. **Simultaneous pulses.** `player_move`, `e0_move` and `e1_move` on the same edge. Required: service order player, e0, e1, with a single IDLE cycle between services and no lost request.
4. **Edge clipping.** e0 at (158,118), width 4. Required: 16 cycles per square, `plot`=1 only for the 4 pixels at x 158..159, y 118..119.
5. **Clear during a sprite.** Assert `clear_req` mid-DRAW of e1. Required: e1 finishes its square, then CLEAR runs for 19200 cycles, then all three sprites redraw with no erase phase.
6. **Re-pulse during own service.** Pulse `e0_move` during e0's ERASE. Required: after the current service finishes, e0 is serviced again, using coordinates sampled at the second latch.
